// File: rtl/wb_ram_responder.sv
// Wishbone classic single-beat slave: byte-enabled RAM with programmable wait states,
// out-of-range error response and wrapping read/write counters exported as status.
module wb_ram_responder #(
  parameter int DW          = 32,
  parameter int S_Aw        = 7,
  parameter int SELw        = 4,
  parameter int TAGw        = 3,
  parameter int MEM_DEPTH   = 128,
  parameter int WAIT_STATES = 1,
  parameter int CNTW        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DW-1:0]     s_dat_i,
  input  logic [SELw-1:0]   s_sel_i,
  input  logic [S_Aw-1:0]   s_addr_i,
  input  logic [TAGw-1:0]   s_cti_i,
  input  logic              s_stb_i,
  input  logic              s_cyc_i,
  input  logic              s_we_i,
  output logic [DW-1:0]     s_dat_o,
  output logic              s_ack_o,
  output logic              s_err_o,
  output logic [2*CNTW-1:0] status_o
);

  localparam int WCW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [S_Aw:0] DEPTH_L = (S_Aw + 1)'(MEM_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_ERR} state_t;

  state_t            state_q, state_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [DW-1:0]     dat_q, dat_d;
  logic [CNTW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [CNTW-1:0]   rd_cnt_q, rd_cnt_d;

  logic [S_Aw-1:0]   addr_q, addr_d;
  logic              we_q, we_d;
  logic [SELw-1:0]   sel_q, sel_d;
  logic [DW-1:0]     wdat_q, wdat_d;
  logic [WCW-1:0]    cnt_q, cnt_d;
  logic              oor_q, oor_d;

  logic [DW-1:0]     mem [MEM_DEPTH];
  logic              req;
  logic              oor;
  logic              mem_we;
  logic [S_Aw-1:0]   rd_addr;
  logic [DW-1:0]     rd_word;
  logic              unused_cti;

  // Cycle type is not acted on; every transfer is handled as classic.
  assign unused_cti = ^s_cti_i;

  assign req = s_stb_i & s_cyc_i;
  assign oor = {1'b0, s_addr_i} >= DEPTH_L;

  // With no wait states the read is launched straight from IDLE using the live address.
  assign rd_addr = (state_q == S_IDLE) ? s_addr_i : addr_q;
  assign rd_word = mem[rd_addr];

  always_comb begin
    state_d  = state_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    dat_d    = dat_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    addr_d   = addr_q;
    we_d     = we_q;
    sel_d    = sel_q;
    wdat_d   = wdat_q;
    cnt_d    = cnt_q;
    oor_d    = oor_q;
    mem_we   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          oor_d = oor;
          cnt_d = WCW'(WAIT_STATES);
          if (!oor) begin
            addr_d = s_addr_i;
            we_d   = s_we_i;
            sel_d  = s_sel_i;
            wdat_d = s_dat_i;
          end
          if (WAIT_STATES == 0) begin
            if (oor) begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end else begin
              state_d = S_ACK;
              ack_d   = 1'b1;
              if (!s_we_i) dat_d = rd_word;
            end
          end else begin
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - WCW'(1);
          if (cnt_q == WCW'(1)) begin
            if (oor_q) begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end else begin
              state_d = S_ACK;
              ack_d   = 1'b1;
              if (!we_q) dat_d = rd_word;
            end
          end
        end
      end

      S_ACK: begin
        state_d = S_IDLE;
        if (we_q) begin
          mem_we   = ~reset;
          wr_cnt_d = wr_cnt_q + CNTW'(1);
        end else begin
          rd_cnt_d = rd_cnt_q + CNTW'(1);
        end
      end

      S_ERR: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      dat_q    <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      dat_q    <= dat_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  // Request capture registers carry data only and need no reset.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    we_q   <= we_d;
    sel_q  <= sel_d;
    wdat_q <= wdat_d;
    cnt_q  <= cnt_d;
    oor_q  <= oor_d;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < SELw; k++) begin
        if (sel_q[k]) mem[addr_q][8*k +: 8] <= wdat_q[8*k +: 8];
      end
    end
  end

  assign s_dat_o  = dat_q;
  assign s_ack_o  = ack_q;
  assign s_err_o  = err_q;
  assign status_o = {wr_cnt_q, rd_cnt_q};

endmodule

// File: tb/tb_wb_ram_responder.sv
// Directed bench for wb_ram_responder: a two-wait-state instance and a zero-wait-state instance.
module tb_wb_ram_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic [31:0] a_dat_i = '0;
  logic [3:0]  a_sel = '0;
  logic [6:0]  a_addr = '0;
  logic [2:0]  a_cti = '0;
  logic        a_stb = 1'b0, a_cyc = 1'b0, a_we = 1'b0;
  logic [31:0] a_dat_o;
  logic        a_ack, a_err;
  logic [7:0]  a_status;

  logic [31:0] b_dat_i = '0;
  logic [3:0]  b_sel = '0;
  logic [6:0]  b_addr = '0;
  logic [2:0]  b_cti = '0;
  logic        b_stb = 1'b0, b_cyc = 1'b0, b_we = 1'b0;
  logic [31:0] b_dat_o;
  logic        b_ack, b_err;
  logic [7:0]  b_status;

  int checks = 0;
  int failures = 0;
  logic [31:0] seen;

  always #5 clk = ~clk;

  wb_ram_responder #(.DW(32), .S_Aw(7), .SELw(4), .TAGw(3), .MEM_DEPTH(100),
                     .WAIT_STATES(2), .CNTW(4)) u_dut (
    .clk(clk), .reset(reset), .s_dat_i(a_dat_i), .s_sel_i(a_sel), .s_addr_i(a_addr),
    .s_cti_i(a_cti), .s_stb_i(a_stb), .s_cyc_i(a_cyc), .s_we_i(a_we),
    .s_dat_o(a_dat_o), .s_ack_o(a_ack), .s_err_o(a_err), .status_o(a_status));

  wb_ram_responder #(.DW(32), .S_Aw(7), .SELw(4), .TAGw(3), .MEM_DEPTH(100),
                     .WAIT_STATES(0), .CNTW(4)) u_dut0 (
    .clk(clk), .reset(reset), .s_dat_i(b_dat_i), .s_sel_i(b_sel), .s_addr_i(b_addr),
    .s_cti_i(b_cti), .s_stb_i(b_stb), .s_cyc_i(b_cyc), .s_we_i(b_we),
    .s_dat_o(b_dat_o), .s_ack_o(b_ack), .s_err_o(b_err), .status_o(b_status));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full transfer on the two-wait-state instance; request inputs are scrambled
  // during the wait cycles and must be ignored.
  task automatic xfer(input logic we, input logic [6:0] addr, input logic [31:0] dat,
                      input logic [3:0] sel, input logic exp_err, output logic [31:0] dat_seen);
    a_cyc = 1'b1; a_stb = 1'b1; a_we = we; a_addr = addr; a_dat_i = dat; a_sel = sel;
    tick;
    chk("wait1_ack", a_ack, 0);
    chk("wait1_err", a_err, 0);
    a_we = ~we; a_addr = addr ^ 7'h01; a_dat_i = ~dat; a_sel = ~sel;
    tick;
    chk("wait2_ack", a_ack, 0);
    chk("wait2_err", a_err, 0);
    tick;
    chk("resp_ack", a_ack, {31'b0, ~exp_err});
    chk("resp_err", a_err, {31'b0, exp_err});
    dat_seen = a_dat_o;
    a_cyc = 1'b0; a_stb = 1'b0; a_we = 1'b0;
    tick;
    chk("post_ack", a_ack, 0);
    chk("post_err", a_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    tick; tick;
    chk("rst_ack", a_ack, 0);
    chk("rst_err", a_err, 0);
    chk("rst_dat", a_dat_o, 32'h0);
    chk("rst_status", a_status, 8'h00);
    reset = 1'b0;
    tick;

    // Full-word write then read
    xfer(1'b1, 7'd5, 32'hDEADBEEF, 4'b1111, 1'b0, seen);
    xfer(1'b0, 7'd5, 32'h0, 4'b1111, 1'b0, seen);
    chk("rd5_dat", seen, 32'hDEADBEEF);
    chk("status_11", a_status, 8'h11);

    // Partial byte write
    xfer(1'b1, 7'd5, 32'h11223344, 4'b0101, 1'b0, seen);
    xfer(1'b0, 7'd5, 32'h0, 4'b1111, 1'b0, seen);
    chk("rd5_bytes", seen, 32'hDE22BE44);
    chk("status_22", a_status, 8'h22);

    // Out-of-range read and write
    xfer(1'b0, 7'd100, 32'h0, 4'b1111, 1'b1, seen);
    chk("err_status", a_status, 8'h22);
    chk("err_dat", a_dat_o, 32'hDE22BE44);
    xfer(1'b1, 7'd100, 32'h12345678, 4'b1111, 1'b1, seen);
    chk("errw_status", a_status, 8'h22);

    // Last valid word
    xfer(1'b1, 7'd99, 32'hCAFEF00D, 4'b1111, 1'b0, seen);
    xfer(1'b0, 7'd99, 32'h0, 4'b1111, 1'b0, seen);
    chk("rd99_dat", seen, 32'hCAFEF00D);
    chk("status_33", a_status, 8'h33);

    // Aborted write: strobe dropped during the first wait cycle
    a_cyc = 1'b1; a_stb = 1'b1; a_we = 1'b1; a_addr = 7'd5; a_dat_i = 32'hFFFFFFFF; a_sel = 4'hF;
    tick;
    a_stb = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("abort_ack", a_ack, 0);
      chk("abort_err", a_err, 0);
    end
    a_cyc = 1'b0; a_we = 1'b0;
    chk("abort_status", a_status, 8'h33);
    xfer(1'b0, 7'd5, 32'h0, 4'b1111, 1'b0, seen);
    chk("abort_rd5", seen, 32'hDE22BE44);
    chk("abort_status2", a_status, 8'h34);

    // Counter wrap: clear counters, then 17 writes
    reset = 1'b1;
    tick;
    chk("rst2_status", a_status, 8'h00);
    reset = 1'b0;
    tick;
    for (int i = 0; i < 17; i++) begin
      xfer(1'b1, 7'(10 + i), 32'h10000000 + 32'(i), 4'b1111, 1'b0, seen);
    end
    chk("wrap_status", a_status, 8'h10);
    xfer(1'b0, 7'd12, 32'h0, 4'b1111, 1'b0, seen);
    chk("rd12_dat", seen, 32'h10000002);
    chk("status_11b", a_status, 8'h11);

    // Reset during the wait of a write to address 5
    a_cyc = 1'b1; a_stb = 1'b1; a_we = 1'b1; a_addr = 7'd5; a_dat_i = 32'h00000000; a_sel = 4'hF;
    tick;
    reset = 1'b1;
    #1;
    chk("midrst_ack", a_ack, 0);
    chk("midrst_err", a_err, 0);
    chk("midrst_dat", a_dat_o, 32'h0);
    chk("midrst_status", a_status, 8'h00);
    a_cyc = 1'b0; a_stb = 1'b0; a_we = 1'b0;
    tick;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("postrst_ack", a_ack, 0);
    end
    xfer(1'b0, 7'd5, 32'h0, 4'b1111, 1'b0, seen);
    chk("keep_rd5", seen, 32'hDE22BE44);
    xfer(1'b0, 7'd26, 32'h0, 4'b1111, 1'b0, seen);
    chk("keep_rd26", seen, 32'h10000010);
    chk("status_02", a_status, 8'h02);

    // Zero-wait instance: ack next cycle, back-to-back with strobe held high
    b_cyc = 1'b1; b_stb = 1'b1; b_we = 1'b1; b_addr = 7'd3; b_dat_i = 32'hA5A5A5A5; b_sel = 4'hF;
    tick;
    chk("z_wr_ack", b_ack, 1);
    b_we = 1'b0;
    tick;
    chk("z_idle1_ack", b_ack, 0);
    tick;
    chk("z_rd1_ack", b_ack, 1);
    chk("z_rd1_dat", b_dat_o, 32'hA5A5A5A5);
    tick;
    chk("z_idle2_ack", b_ack, 0);
    tick;
    chk("z_rd2_ack", b_ack, 1);
    b_cyc = 1'b0; b_stb = 1'b0;
    tick;
    chk("z_idle3_ack", b_ack, 0);
    chk("z_status", b_status, 8'h12);
    b_cyc = 1'b1; b_stb = 1'b1; b_addr = 7'd120;
    tick;
    chk("z_err", b_err, 1);
    chk("z_err_ack", b_ack, 0);
    b_cyc = 1'b0; b_stb = 1'b0;
    tick;
    chk("z_err_post", b_err, 0);
    chk("z_err_status", b_status, 8'h12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
